// File: rtl/seout.sv
// ---------------------------------------------------------------------------
// seout -- eight-lane update serializer.
//
// An 8-entry bank (one 64-bit word plus a pending flag per lane) captures
// all lanes in a single cycle. It then drains one word per cycle in
// ascending lane order onto a single registered output. While captured
// words are still waiting, the block asks upstream to hold its lanes.
//
// Ports:
//   clk                     clock, all state changes on its rising edge
//   rst                     asynchronous active-high reset
//   input_update0..7 [63:0] lane update words
//   input_valid0..7         lane qualifiers
//   output_word [63:0]      serialized word (registered)
//   output_valid            output_word qualifier (registered)
//   se_stall_request        hold request to upstream (combinational from state)
//
// Build option:
//   SEOUT_LOOKAHEAD_EN  When defined, the edge that drains the last pending
//                       entry also captures the lanes, so back-to-back sets
//                       stream with no idle cycle. Stall is then raised only
//                       while two or more entries are pending.
// ---------------------------------------------------------------------------
module seout (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] input_update0,
  input  logic [63:0] input_update1,
  input  logic [63:0] input_update2,
  input  logic [63:0] input_update3,
  input  logic [63:0] input_update4,
  input  logic [63:0] input_update5,
  input  logic [63:0] input_update6,
  input  logic [63:0] input_update7,
  input  logic        input_valid0,
  input  logic        input_valid1,
  input  logic        input_valid2,
  input  logic        input_valid3,
  input  logic        input_valid4,
  input  logic        input_valid5,
  input  logic        input_valid6,
  input  logic        input_valid7,
  output logic [63:0] output_word,
  output logic        output_valid,
  output logic        se_stall_request
);

  logic [63:0] lane_word [8];
  logic [7:0]  lane_valid;

  logic [63:0] bank [8];
  logic [7:0]  pending;

  logic [2:0]  drain_idx;
  logic        any_pending;
  logic        multi_pending;
  logic        capture;

  assign lane_word[0] = input_update0;
  assign lane_word[1] = input_update1;
  assign lane_word[2] = input_update2;
  assign lane_word[3] = input_update3;
  assign lane_word[4] = input_update4;
  assign lane_word[5] = input_update5;
  assign lane_word[6] = input_update6;
  assign lane_word[7] = input_update7;

  assign lane_valid = {input_valid7, input_valid6, input_valid5, input_valid4,
                       input_valid3, input_valid2, input_valid1, input_valid0};

  // Lowest-index pending entry; scanning downward lets lower lanes win.
  always_comb begin
    drain_idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (pending[i]) drain_idx = 3'(i);
    end
  end

  assign any_pending = |pending;
  // Clearing the lowest set bit leaves something only if two or more are set.
  assign multi_pending = |(pending & (pending - 8'd1));

`ifdef SEOUT_LOOKAHEAD_EN
  // With at most one entry left, it drains this edge while the lanes
  // are captured behind it.
  assign se_stall_request = multi_pending;
  assign capture          = ~multi_pending;
`else
  assign se_stall_request = any_pending;
  assign capture          = ~any_pending;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending      <= 8'd0;
      output_word  <= 64'd0;
      output_valid <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        bank[i] <= 64'd0;
      end
    end else begin
      // Drain reads the bank contents from before this edge, so a capture
      // on the same edge cannot disturb the word being sent.
      if (any_pending) begin
        output_word  <= bank[drain_idx];
        output_valid <= 1'b1;
      end else begin
        output_valid <= 1'b0;
      end

      if (capture) begin
        // Replaces every pending bit, which also retires the entry drained
        // on this edge in the lookahead build.
        pending <= lane_valid;
        for (int i = 0; i < 8; i++) begin
          bank[i] <= lane_word[i];
        end
      end else if (any_pending) begin
        pending[drain_idx] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seout.sv
module tb_seout;

  logic        clk;
  logic        rst;
  logic [63:0] lane_word [8];
  logic [7:0]  lane_valid;
  logic [63:0] output_word;
  logic        output_valid;
  logic        se_stall_request;

  int checks = 0;
  int errors = 0;

  logic [63:0] exp_q [$];
  logic [63:0] full_set [8];

`ifdef SEOUT_LOOKAHEAD_EN
  localparam int FULL_STALL = 7;
  localparam int SPARSE_STALL = 1;
`else
  localparam int FULL_STALL = 8;
  localparam int SPARSE_STALL = 2;
`endif

  seout dut (
    .clk              (clk),
    .rst              (rst),
    .input_update0    (lane_word[0]),
    .input_update1    (lane_word[1]),
    .input_update2    (lane_word[2]),
    .input_update3    (lane_word[3]),
    .input_update4    (lane_word[4]),
    .input_update5    (lane_word[5]),
    .input_update6    (lane_word[6]),
    .input_update7    (lane_word[7]),
    .input_valid0     (lane_valid[0]),
    .input_valid1     (lane_valid[1]),
    .input_valid2     (lane_valid[2]),
    .input_valid3     (lane_valid[3]),
    .input_valid4     (lane_valid[4]),
    .input_valid5     (lane_valid[5]),
    .input_valid6     (lane_valid[6]),
    .input_valid7     (lane_valid[7]),
    .output_word      (output_word),
    .output_valid     (output_valid),
    .se_stall_request (se_stall_request)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: every presented output must match the oldest expected word.
  always @(negedge clk) begin
    if (!rst && output_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL out_word: unexpected output %h, none expected", output_word);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        if (output_word !== e) begin
          errors++;
          $display("FAIL out_word: got %h expected %h", output_word, e);
        end else begin
          $display("out_word %h ok", output_word);
        end
      end
    end
  end

  task automatic check_bit(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  task automatic load_full();
    for (int i = 0; i < 8; i++) lane_word[i] = full_set[i];
  endtask

  // Returns at a falling edge with stall low; the next rising edge captures.
  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (se_stall_request !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL wait_idle: stall %b still high after %0d cycles", se_stall_request, n);
    end
  endtask

  // Capture one set; returns 1 time unit after the capture edge with valids low.
  task automatic apply(input logic [7:0] v);
    wait_idle();
    lane_valid = v;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) exp_q.push_back(lane_word[i]);
    end
    @(posedge clk);
    #1;
    lane_valid = 8'd0;
  endtask

  initial begin
    full_set[0] = 64'h0000000A0000000A;
    full_set[1] = 64'h0000000B0000000B;
    full_set[2] = 64'h0000000C0000000C;
    full_set[3] = 64'h0000000D0000000D;
    full_set[4] = 64'h0000000E0000000E;
    full_set[5] = 64'h0000000F0000000F;
    full_set[6] = 64'h0000000100000001;
    full_set[7] = 64'h0000000200000002;
    for (int i = 0; i < 8; i++) lane_word[i] = 64'd0;
    lane_valid = 8'd0;

    // Reset held for 3 cycles, even with valid lanes presented.
    rst = 1'b1;
    load_full();
    lane_valid = 8'hFF;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_bit("rst_valid", output_valid, 1'b0);
      check_bit("rst_stall", se_stall_request, 1'b0);
      checks++;
      if (output_word !== 64'd0) begin
        errors++;
        $display("FAIL rst_word: got %h expected 0", output_word);
      end
    end
    lane_valid = 8'd0;
    rst = 1'b0;
    $display("reset phase done");

    // Full set: 8 consecutive outputs in lane order.
    load_full();
    apply(8'hFF);
    for (int k = 0; k <= 9; k++) begin
      @(negedge clk);
      check_bit($sformatf("full_valid_k%0d", k), output_valid, (k >= 1 && k <= 8));
      if (k <= 8) check_bit($sformatf("full_stall_k%0d", k), se_stall_request, (k < FULL_STALL));
    end
    $display("full set done");

    // Sparse set: lanes 2 and 6 only.
    apply(8'b0100_0100);
    for (int k = 0; k <= 3; k++) begin
      @(negedge clk);
      check_bit($sformatf("sparse_valid_k%0d", k), output_valid, (k == 1 || k == 2));
      check_bit($sformatf("sparse_stall_k%0d", k), se_stall_request, (k < SPARSE_STALL));
    end
    $display("sparse set done");

    // Empty capture: no output at all.
    apply(8'h00);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_bit("empty_valid", output_valid, 1'b0);
      check_bit("empty_stall", se_stall_request, 1'b0);
    end
    $display("empty set done");

    // Full set held for 20 edges: three captures in either build.
    wait_idle();
    lane_valid = 8'hFF;
    for (int s = 0; s < 3; s++)
      for (int i = 0; i < 8; i++) exp_q.push_back(full_set[i]);
    for (int k = 0; k <= 27; k++) begin
      @(negedge clk);
      if (k == 19) lane_valid = 8'd0;
`ifdef SEOUT_LOOKAHEAD_EN
      check_bit($sformatf("held_valid_k%0d", k), output_valid, (k >= 1 && k <= 24));
`else
      check_bit($sformatf("held_valid_k%0d", k), output_valid, (k >= 1 && k <= 26 && (k % 9) != 0));
`endif
    end
    $display("held inputs done");

    // Reset after 3 outputs of a full set.
    apply(8'hFF);
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_bit("mid_rst_valid", output_valid, 1'b0);
    check_bit("mid_rst_stall", se_stall_request, 1'b0);
    checks++;
    if (output_word !== 64'd0) begin
      errors++;
      $display("FAIL mid_rst_word: got %h expected 0", output_word);
    end
    checks++;
    if (exp_q.size() != 5) begin
      errors++;
      $display("FAIL mid_rst_count: %0d words pending, expected 5", exp_q.size());
    end
    exp_q.delete();
    @(posedge clk);
    #2 rst = 1'b0;
    apply(8'hFF);
    repeat (10) @(negedge clk);
    $display("mid-drain reset done");

    // Lanes changed while stalled must never reach the output.
    apply(8'hFF);
    for (int i = 0; i < 8; i++) lane_word[i] = 64'hDEAD_0000_0000_0000 | 64'(i);
    lane_valid = 8'hFF;
    repeat (5) @(negedge clk);
    lane_valid = 8'd0;
    repeat (10) @(negedge clk);
    $display("stall violation done");

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_all: %0d words never output, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seout.md
SEOUT -- requirements
Module: seout

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-003 SHALL have ports input_update0..input_update7, input, 64 bits each: update words, one per lane.
REQ-004 SHALL have ports input_valid0..input_valid7, input, 1 bit each: lane N update qualifier.
REQ-005 SHALL have port output_word, output, 64 bits: serialized update word, registered.
REQ-006 SHALL have port output_valid, output, 1 bit: output_word qualifier, registered.
REQ-007 SHALL have port se_stall_request, output, 1 bit: upstream must hold lanes while high; combinational from internal state only.

Function
REQ-008 SHALL hold an 8-entry bank (64-bit word plus pending bit per entry), entry N bound to lane N.
REQ-009 SHALL assert se_stall_request exactly when any pending bit is set (default build).
REQ-010 While se_stall_request is low, on a rising edge SHALL latch every lane word into its entry and set pending[N] = input_valid[N]; invalid lanes leave pending clear.
REQ-011 While se_stall_request is high, SHALL ignore all lane inputs; upstream honouring stall is a precondition, and words presented then are lost.
REQ-012 Each rising edge with pending nonzero SHALL drive output_word to the lowest-index pending entry, set output_valid to 1 and clear that pending bit.
REQ-013 Each rising edge with pending zero SHALL set output_valid to 0 and hold output_word at its last value.
REQ-014 Capture and drain SHALL NOT occur on the same edge in the default build; first output appears one edge after capture.
REQ-015 Words SHALL pass through unmodified, with no arithmetic, in ascending lane order within a capture set.
REQ-016 A capture with all valids low SHALL leave the bank empty and produce no output.
REQ-017 A capture of k valid lanes (1 to 8) SHALL produce exactly k consecutive output_valid cycles; stall is high for those k cycles.

Reset
REQ-018 While rst is high, SHALL clear all pending bits, bank words, output_word (0) and output_valid (0), independent of clk.
REQ-019 se_stall_request SHALL be 0 during reset; a reset asserted mid-drain SHALL discard remaining entries with no further output.
REQ-020 The first capture SHALL occur on the first rising edge after rst deasserts.

Configuration
REQ-021 With SEOUT_LOOKAHEAD_EN defined, se_stall_request SHALL be high only when two or more bits are pending, and an edge that drains the last pending entry SHALL also capture the lanes; back-to-back sets then stream with no idle cycle.
REQ-022 Without SEOUT_LOOKAHEAD_EN, behaviour SHALL be exactly REQ-009 and REQ-014, giving one idle or capture cycle between sets.

Verification
REQ-023 Reset: rst=1 for 3 cycles -> output_valid=0, output_word=0, se_stall_request=0 throughout.
REQ-024 Full set: all valids=1, lanes 0..7 = 0x0000000A0000000A, 0x0000000B0000000B, 0x0000000C0000000C, 0x0000000D0000000D, 0x0000000E0000000E, 0x0000000F0000000F, 0x0000000100000001, 0x0000000200000002 -> 8 consecutive valid outputs in that order starting the edge after capture; stall high for those 8 cycles.
REQ-025 Sparse set: only valid2 and valid6 set (0xC.., 0x1..) -> outputs 0x0000000C0000000C then 0x0000000100000001, then output_valid=0.
REQ-026 Held inputs: the REQ-024 set held constant for 20 cycles -> the sequence repeats every 9 cycles by default, or every 8 cycles with no gap under SEOUT_LOOKAHEAD_EN.
REQ-027 Mid-drain reset: rst pulsed after 3 outputs of the full set -> output_valid drops immediately and stall=0; next capture restarts at lane 0.
REQ-028 Stall violation: lanes changed while stall is high -> the changed values never appear on output_word.
